uart_number_parser: RTL and testbench

Upstream value source for the OLED visualisation rows. Consumes the byte stream from the uart receiver and parses ASCII numbers in decimal, or in hex with a "0x" prefix. Each complete number is committed to an 8-bit value register that drives the binary, hex/dec and progress rows in place of the free-running counter. Malformed input, out-of-range values and stalled partial numbers are rejected without disturbing the displayed value.

---
 rtl/uart_number_parser.sv | 193 +++++++++++++++++++
 tb/tb_uart_number_parser.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_number_parser.sv
// Turns the uart byte stream into 8-bit values for the OLED rows. It accepts
// decimal numbers or hex numbers with a "0x" prefix, each ended by CR, LF or space.
module uart_number_parser #(
  parameter logic [7:0]  DEFAULT_VALUE  = 8'd0,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd27000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byteReady,
  input  logic [7:0] byteIn,
  output logic [7:0] value,
  output logic       valueUpdated,
  output logic       parseError,
  output logic       busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ZERO     = 3'd1;
  localparam logic [2:0] DEC      = 3'd2;
  localparam logic [2:0] HEXSTART = 3'd3;
  localparam logic [2:0] HEX      = 3'd4;
  localparam logic [2:0] DISCARD  = 3'd5;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);

  logic [2:0]  stateReg, stateNext;
  logic [11:0] accReg, accNext;
  logic [31:0] timerReg, timerNext;
  logic [7:0]  valueReg;
  logic        updatedReg, errorReg;
  logic        commitNext, errorNext;

  // Byte classification and digit value
  logic        isDig, isHexl, isX, isTerm;
  logic [3:0]  digitVal;
  logic [11:0] decStep, hexStep;
  logic        decOverflow, hexOverflow;

  always_comb begin
    isDig  = (byteIn >= 8'h30) && (byteIn <= 8'h39);
    isHexl = ((byteIn >= 8'h61) && (byteIn <= 8'h66)) ||
             ((byteIn >= 8'h41) && (byteIn <= 8'h46));
    isX    = (byteIn == 8'h78) || (byteIn == 8'h58);
    isTerm = (byteIn == 8'h0D) || (byteIn == 8'h0A) || (byteIn == 8'h20);

    digitVal = 4'd0;
    if (isDig)
      digitVal = 4'(byteIn - 8'h30);
    else if ((byteIn >= 8'h61) && (byteIn <= 8'h66))
      digitVal = 4'(byteIn - 8'h57);
    else if ((byteIn >= 8'h41) && (byteIn <= 8'h46))
      digitVal = 4'(byteIn - 8'h37);

    // accReg never exceeds 255, so neither step can wrap in 12 bits.
    decStep     = (accReg * 12'd10) + {8'd0, digitVal};
    hexStep     = (accReg << 4) + {8'd0, digitVal};
    decOverflow = (decStep > 12'd255);
    hexOverflow = (hexStep > 12'd255);
  end

  always_comb begin
    stateNext  = stateReg;
    accNext    = accReg;
    timerNext  = timerReg;
    commitNext = 1'b0;
    errorNext  = 1'b0;

    if (byteReady) begin
      timerNext = 32'd0;
      case (stateReg)
        IDLE: begin
          if (isDig) begin
            stateNext = (digitVal == 4'd0) ? ZERO : DEC;
            accNext   = {8'd0, digitVal};
          end else if (!isTerm) begin
            stateNext = DISCARD;
            errorNext = 1'b1;
          end
        end
        ZERO: begin
          if (isX) begin
            stateNext = HEXSTART;
          end else if (isDig) begin
            stateNext = DEC;
            accNext   = {8'd0, digitVal};
          end else if (isTerm) begin
            stateNext  = IDLE;
            accNext    = 12'd0;
            commitNext = 1'b1;
          end else begin
            stateNext = DISCARD;
            errorNext = 1'b1;
          end
        end
        DEC: begin
          if (isDig) begin
            if (decOverflow) begin
              stateNext = DISCARD;
              errorNext = 1'b1;
            end else begin
              accNext = decStep;
            end
          end else if (isTerm) begin
            stateNext  = IDLE;
            accNext    = 12'd0;
            commitNext = 1'b1;
          end else begin
            stateNext = DISCARD;
            errorNext = 1'b1;
          end
        end
        HEXSTART: begin
          if (isDig || isHexl) begin
            stateNext = HEX;
            accNext   = {8'd0, digitVal};
          end else if (isTerm) begin
            // "0x" with no digits is rejected without a discard phase.
            stateNext = IDLE;
            accNext   = 12'd0;
            errorNext = 1'b1;
          end else begin
            stateNext = DISCARD;
            errorNext = 1'b1;
          end
        end
        HEX: begin
          if (isDig || isHexl) begin
            if (hexOverflow) begin
              stateNext = DISCARD;
              errorNext = 1'b1;
            end else begin
              accNext = hexStep;
            end
          end else if (isTerm) begin
            stateNext  = IDLE;
            accNext    = 12'd0;
            commitNext = 1'b1;
          end else begin
            stateNext = DISCARD;
            errorNext = 1'b1;
          end
        end
        DISCARD: begin
          if (isTerm) begin
            stateNext = IDLE;
            accNext   = 12'd0;
          end
        end
        default: begin
          stateNext = IDLE;
          accNext   = 12'd0;
        end
      endcase
    end else if (stateReg == IDLE) begin
      timerNext = 32'd0;
    end else if (TIMEOUT_EN) begin
      if (timerReg == TIMEOUT_CYCLES - 32'd1) begin
        // A stalled partial number is abandoned; an already-bad one leaves quietly.
        stateNext = IDLE;
        accNext   = 12'd0;
        timerNext = 32'd0;
        errorNext = (stateReg != DISCARD);
      end else begin
        timerNext = timerReg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      accReg     <= 12'd0;
      timerReg   <= 32'd0;
      valueReg   <= DEFAULT_VALUE;
      updatedReg <= 1'b0;
      errorReg   <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      accReg     <= accNext;
      timerReg   <= timerNext;
      updatedReg <= commitNext;
      errorReg   <= errorNext;
      if (commitNext)
        valueReg <= accReg[7:0];
    end
  end

  assign value        = valueReg;
  assign valueUpdated = updatedReg;
  assign parseError   = errorReg;
  assign busy         = (stateReg != IDLE);

endmodule

// File: tb/tb_uart_number_parser.sv
// Scoreboard bench: the driver queues expected pulses (kind, value, cycle) and
// a monitor checks every pulse the parser produces against that queue.
module tb_uart_number_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       byteReady = 1'b0;
  logic [7:0] byteIn = 8'd0;
  logic [7:0] value;
  logic       valueUpdated, parseError, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit         isErr;
    logic [7:0] val;
    int         cyc;
  } ev_t;

  ev_t expQ[$];

  uart_number_parser #(
    .DEFAULT_VALUE (8'd5),
    .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .byteReady   (byteReady),
    .byteIn      (byteIn),
    .value       (value),
    .valueUpdated(valueUpdated),
    .parseError  (parseError),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Monitor: samples 1 ns after each rising edge.
  logic [7:0] prevVal = 8'd0;
  always begin
    logic rstAt;
    ev_t  e;
    @(posedge clk);
    rstAt = reset;
    cyc = cyc + 1;
    #1;
    if (valueUpdated && parseError) begin
      checks++;
      errors++;
      $display("FAIL pulse_overlap cycle=%0d valueUpdated and parseError both high", cyc);
    end else if (valueUpdated || parseError) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cycle=%0d updated=%0b error=%0b value=%0d",
                 cyc, valueUpdated, parseError, value);
      end else begin
        e = expQ.pop_front();
        if (e.isErr != parseError || e.cyc != cyc || (!e.isErr && value !== e.val)) begin
          errors++;
          $display("FAIL pulse actual: err=%0b cycle=%0d value=%0d required: err=%0b cycle=%0d value=%0d",
                   parseError, cyc, value, e.isErr, e.cyc, e.val);
        end else begin
          $display("ok   %s cycle=%0d value=%0d", e.isErr ? "parseError  " : "valueUpdated", cyc, value);
        end
      end
    end
    if (!rstAt && value !== prevVal) begin
      checks++;
      if (!valueUpdated) begin
        errors++;
        $display("FAIL value_change cycle=%0d actual=%0d from=%0d without valueUpdated",
                 cyc, value, prevVal);
      end
    end
    prevVal = value;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Called at a falling edge; one byte per cycle, then one idle cycle.
  task automatic sendStr(input string s, input int errIdx, input int comIdx,
                         input logic [7:0] comVal);
    for (int i = 0; i < s.len(); i++) begin
      if (i == errIdx) expQ.push_back('{isErr: 1'b1, val: 8'd0, cyc: cyc + 1});
      if (i == comIdx) expQ.push_back('{isErr: 1'b0, val: comVal, cyc: cyc + 1});
      byteReady = 1'b1;
      byteIn    = s[i];
      @(negedge clk);
    end
    byteReady = 1'b0;
    byteIn    = 8'd0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    chk("reset_value", value, 8'd5);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_updated", {7'd0, valueUpdated}, 8'd0);
    chk("reset_error", {7'd0, parseError}, 8'd0);
    reset = 1'b0;
    @(negedge clk);

    sendStr("200\n", -1, 3, 8'd200);
    chk("busy_after_200", {7'd0, busy}, 8'd0);
    sendStr("0x1F\015\n", -1, 4, 8'd31);
    sendStr("0XaB ", -1, 4, 8'd171);

    sendStr("256", 2, -1, 8'd0);
    chk("busy_in_discard", {7'd0, busy}, 8'd1);
    sendStr("\n", -1, -1, 8'd0);
    chk("busy_after_discard", {7'd0, busy}, 8'd0);
    chk("value_after_256", value, 8'd171);

    sendStr("0x100\n", 4, -1, 8'd0);
    sendStr("12q34\n", 2, -1, 8'd0);
    sendStr("7\n", -1, 1, 8'd7);
    sendStr("0x\n", 2, -1, 8'd0);
    chk("value_after_0x", value, 8'd7);
    sendStr("\015\n\015\n", -1, -1, 8'd0);
    sendStr("0042\n", -1, 4, 8'd42);
    sendStr("0x00FF\n", -1, 6, 8'd255);
    sendStr("255\n", -1, 3, 8'd255);
    sendStr("x5\n", 0, -1, 8'd0);
    sendStr("1a\n", 1, -1, 8'd0);
    sendStr("0\n", -1, 1, 8'd0);
    sendStr("09\n", -1, 2, 8'd9);

    // Timeout: '4' then 100 idle clocks abandons the number.
    c0 = cyc + 1;
    expQ.push_back('{isErr: 1'b1, val: 8'd0, cyc: c0 + 100});
    sendStr("4", -1, -1, 8'd0);
    repeat (c0 + 99 - cyc) @(negedge clk);
    chk("busy_before_timeout", {7'd0, busy}, 8'd1);
    @(negedge clk);
    chk("busy_after_timeout", {7'd0, busy}, 8'd0);
    sendStr("9\n", -1, 1, 8'd9);

    // A byte landing on the expiry cycle continues the number.
    c0 = cyc + 1;
    sendStr("4", -1, -1, 8'd0);
    repeat (c0 + 99 - cyc) @(negedge clk);
    sendStr("2\n", -1, 1, 8'd42);

    // Timeout inside DISCARD is silent.
    sendStr("x", 0, -1, 8'd0);
    repeat (105) @(negedge clk);
    chk("busy_after_discard_timeout", {7'd0, busy}, 8'd0);

    // Reset in the middle of a number.
    sendStr("1", -1, -1, 8'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_value", value, 8'd5);
    chk("midreset_busy", {7'd0, busy}, 8'd0);
    sendStr("5\n", -1, 1, 8'd5);

    repeat (5) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses actual=%0d outstanding required=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
